cycloneii_clk_delay_cal_sequencer: RTL and testbench

- Calibration sequencer for the Cyclone II clock delay calibration control atom.
- Sweeps the 6-bit delay code on that atom's delayctrlin from 0 upward.
- For each code: lets the delay chain settle, then majority-votes a phase sample taken from the atom's delayed calibrate clock against its data clock.
- Stops at the first code where the vote flips, then drives the final (offset) code and holds the atom's divider in disable.

---
 rtl/cycloneii_clk_delay_cal_sequencer_pkg.sv | 33 +++
 rtl/cycloneii_clk_delay_cal_sequencer_if.sv | 25 ++
 rtl/cycloneii_clk_delay_cal_sequencer_sync2.sv | 22 ++
 rtl/cycloneii_clk_delay_cal_sequencer.sv | 142 ++++++++++++++
 tb/tb_cycloneii_clk_delay_cal_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cycloneii_clk_delay_cal_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the Cyclone II clock
// delay calibration sequencer.
package cycloneii_clk_delay_cal_pkg;

    localparam int CODE_W = 6;
    localparam logic [CODE_W-1:0] CODE_MAX = 6'd63;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_SAMPLE = 3'd2;
    localparam logic [2:0] ST_EVAL   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_FAIL   = 3'd5;

    // Named view of the same encoding for waveform viewers.
    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_SETTLE = ST_SETTLE,
        S_SAMPLE = ST_SAMPLE,
        S_EVAL   = ST_EVAL,
        S_DONE   = ST_DONE,
        S_FAIL   = ST_FAIL
    } state_e;

    // Code plus offset, widened by one bit and clamped to the top code.
    function automatic logic [CODE_W-1:0] sat_add(input logic [CODE_W-1:0] a,
                                                  input logic [CODE_W-1:0] b);
        logic [CODE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, CODE_MAX}) ? CODE_MAX : sum[CODE_W-1:0];
    endfunction

endpackage

// File: rtl/cycloneii_clk_delay_cal_sequencer_if.sv
// Control/status bundle between a calibration controller and the sequencer.
interface cycloneii_clk_delay_cal_sequencer_if;
    import cycloneii_clk_delay_cal_pkg::*;

    logic              start;
    logic              abort;
    logic              phase_in;
    logic [CODE_W-1:0] delayctrlout;
    logic              disablecalibration;
    logic              busy;
    logic              done;
    logic              fail;
    logic [CODE_W-1:0] cal_code;

    modport master (
        output start, abort, phase_in,
        input  delayctrlout, disablecalibration, busy, done, fail, cal_code
    );

    modport slave (
        input  start, abort, phase_in,
        output delayctrlout, disablecalibration, busy, done, fail, cal_code
    );

endinterface

// File: rtl/cycloneii_clk_delay_cal_sequencer_sync2.sv
// Two-flop synchronizer for the asynchronous phase sample; clears to 0.
module cycloneii_clk_delay_cal_sync2 (
    input  logic clk,
    input  logic areset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments keep the two stages as separate flops.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cycloneii_clk_delay_cal_sequencer.sv
// Sweeps the delay code upward, majority-votes the synchronized phase at each
// code and locks onto the first code whose vote differs from code 0.
module cycloneii_clk_delay_cal_sequencer
    import cycloneii_clk_delay_cal_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLE_COUNT  = 8,
    parameter int CODE_OFFSET   = 0
) (
    input logic clk,
    input logic areset,
    cycloneii_clk_delay_cal_sequencer_if.slave bus
);

    localparam logic [7:0]        SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0]        SAMPLE_LOAD = 8'(SAMPLE_COUNT - 1);
    localparam logic [7:0]        HALF        = 8'(SAMPLE_COUNT / 2);
    localparam logic [CODE_W-1:0] OFFSET      = CODE_W'(CODE_OFFSET);

    logic [2:0]        state;
    logic [CODE_W-1:0] code;
    logic              first_vote;
    logic [7:0]        settle_cnt;
    logic [7:0]        sample_cnt;
    logic [7:0]        ones_cnt;

    logic [CODE_W-1:0] delayctrlout_q;
    logic [CODE_W-1:0] cal_code_q;
    logic              disable_q;
    logic              busy_q;
    logic              done_q;
    logic              fail_q;

    logic              phase_s;
    logic              vote;
    logic              sweeping;
    logic [CODE_W-1:0] result;

    cycloneii_clk_delay_cal_sync2 u_sync (
        .clk    (clk),
        .areset (areset),
        .d      (bus.phase_in),
        .q      (phase_s)
    );

    // A tie (ones == SAMPLE_COUNT/2) votes 0.
    assign vote     = (ones_cnt > HALF);
    assign sweeping = (state == ST_SETTLE) || (state == ST_SAMPLE) || (state == ST_EVAL);
    assign result   = sat_add(code, OFFSET);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state          <= ST_IDLE;
            code           <= '0;
            first_vote     <= 1'b0;
            settle_cnt     <= '0;
            sample_cnt     <= '0;
            ones_cnt       <= '0;
            delayctrlout_q <= '0;
            cal_code_q     <= '0;
            disable_q      <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            fail_q         <= 1'b0;
        end else if (sweeping && bus.abort) begin
            state          <= ST_IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            fail_q         <= 1'b0;
            disable_q      <= 1'b1;
            delayctrlout_q <= cal_code_q;
        end else begin
            case (state)
                ST_SETTLE: begin
                    if (settle_cnt == 8'd0) begin
                        ones_cnt   <= '0;
                        sample_cnt <= SAMPLE_LOAD;
                        state      <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    ones_cnt <= ones_cnt + {7'd0, phase_s};
                    if (sample_cnt == 8'd0) begin
                        state <= ST_EVAL;
                    end else begin
                        sample_cnt <= sample_cnt - 8'd1;
                    end
                end
                ST_EVAL: begin
                    if (code == '0) begin
                        first_vote     <= vote;
                        code           <= 6'd1;
                        delayctrlout_q <= 6'd1;
                        settle_cnt     <= SETTLE_LOAD;
                        state          <= ST_SETTLE;
                    end else if (vote != first_vote) begin
                        delayctrlout_q <= result;
                        cal_code_q     <= result;
                        done_q         <= 1'b1;
                        busy_q         <= 1'b0;
                        disable_q      <= 1'b1;
                        state          <= ST_DONE;
                    end else if (code == CODE_MAX) begin
                        delayctrlout_q <= cal_code_q;
                        fail_q         <= 1'b1;
                        busy_q         <= 1'b0;
                        disable_q      <= 1'b1;
                        state          <= ST_FAIL;
                    end else begin
                        code           <= code + 1'b1;
                        delayctrlout_q <= code + 1'b1;
                        settle_cnt     <= SETTLE_LOAD;
                        state          <= ST_SETTLE;
                    end
                end
                default: begin
                    // Idle, done or fail: start begins a sweep unless abort shares the cycle.
                    if (bus.start && !bus.abort) begin
                        code           <= '0;
                        delayctrlout_q <= '0;
                        disable_q      <= 1'b0;
                        busy_q         <= 1'b1;
                        done_q         <= 1'b0;
                        fail_q         <= 1'b0;
                        settle_cnt     <= SETTLE_LOAD;
                        state          <= ST_SETTLE;
                    end
                end
            endcase
        end
    end

    assign bus.delayctrlout       = delayctrlout_q;
    assign bus.cal_code           = cal_code_q;
    assign bus.disablecalibration = disable_q;
    assign bus.busy               = busy_q;
    assign bus.done               = done_q;
    assign bus.fail               = fail_q;

endmodule

// File: tb/tb_cycloneii_clk_delay_cal_sequencer.sv
// Three sequencers (CODE_OFFSET 0, 2, 5) swept in lockstep by a threshold
// phase source, checked against a code-search reference model.
module tb_cycloneii_clk_delay_cal_sequencer;
    import cycloneii_clk_delay_cal_pkg::*;

    localparam int NI     = 3;
    localparam int SETTLE = 4;
    localparam int SAMPLE = 8;
    localparam int PER    = SETTLE + SAMPLE + 1;

    logic clk = 1'b0;
    logic areset, start, abort;
    int   thr;
    bit   noise_en;
    int   noise_code, noise_k;

    logic [5:0] dco [NI];
    logic [5:0] calc [NI];
    logic       dis [NI], bsy [NI], dn [NI], fl [NI];
    logic [5:0] prior [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int OFF = (g == 0) ? 0 : (g == 1) ? 2 : 5;
        cycloneii_clk_delay_cal_sequencer_if bus ();
        int   nc = 0;
        logic ph;

        // Noise replaces the threshold source while the swept code equals noise_code.
        always @(negedge clk) begin
            if (bus.delayctrlout == 6'(noise_code)) nc <= nc + 1;
            else nc <= 0;
        end
        assign ph = (noise_en && bus.delayctrlout == 6'(noise_code)) ?
                    (nc >= 4 && nc < 4 + noise_k) : (int'(bus.delayctrlout) >= thr);

        assign bus.start    = start;
        assign bus.abort    = abort;
        assign bus.phase_in = ph;
        assign dco[g]  = bus.delayctrlout;
        assign calc[g] = bus.cal_code;
        assign dis[g]  = bus.disablecalibration;
        assign bsy[g]  = bus.busy;
        assign dn[g]   = bus.done;
        assign fl[g]   = bus.fail;

        cycloneii_clk_delay_cal_sequencer #(
            .SETTLE_CYCLES (SETTLE),
            .SAMPLE_COUNT  (SAMPLE),
            .CODE_OFFSET   (OFF)
        ) u_dut (
            .clk    (clk),
            .areset (areset),
            .bus    (bus)
        );
    end

    function automatic int offset_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 2 : 5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit vote_of(input int c, input int t, input bit ne, input int ncode, input int nk);
        if (ne && c == ncode) return (nk > SAMPLE / 2);
        return (c >= t);
    endfunction

    // Reference: first code whose vote differs from code 0, result offset and clamped.
    task automatic model(input int t, input bit ne, input int ncode, input int nk,
                         input logic [5:0] prev, input int off,
                         output bit mfail, output int mcyc, output logic [5:0] mcode);
        bit v0;
        v0    = vote_of(0, t, ne, ncode, nk);
        mfail = 1'b1;
        mcyc  = 64 * PER;
        mcode = prev;
        for (int c = 1; c < 64; c++) begin
            if (vote_of(c, t, ne, ncode, nk) != v0) begin
                mfail = 1'b0;
                mcyc  = (c + 1) * PER;
                mcode = (c + off > 63) ? 6'd63 : 6'(c + off);
                break;
            end
        end
    endtask

    task automatic check_idle_regs(input string tag, input int i, input bit edone, input bit efail,
                                   input logic [5:0] ecode);
        check($sformatf("%s[%0d] done", tag, i), 32'(dn[i]), 32'(edone));
        check($sformatf("%s[%0d] fail", tag, i), 32'(fl[i]), 32'(efail));
        check($sformatf("%s[%0d] busy", tag, i), 32'(bsy[i]), 32'd0);
        check($sformatf("%s[%0d] disablecal", tag, i), 32'(dis[i]), 32'd1);
        check($sformatf("%s[%0d] delayctrlout", tag, i), 32'(dco[i]), 32'(ecode));
        check($sformatf("%s[%0d] cal_code", tag, i), 32'(calc[i]), 32'(ecode));
    endtask

    task automatic run_cal(input string tag, input int t, input bit ne, input int ncode, input int nk,
                           input int restart_at, input bit efail, input int ecyc,
                           input logic [5:0] e0, input logic [5:0] e1, input logic [5:0] e2);
        int n;
        bit seen;
        logic [5:0] e [NI];
        e[0] = e0; e[1] = e1; e[2] = e2;
        thr = t; noise_en = ne; noise_code = ncode; noise_k = nk;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, " busy_after_start"}, 32'(bsy[0]), 32'd1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 2000) begin
            @(negedge clk);
            n++;
            start = (n == restart_at);
            if (dn[0] || fl[0]) seen = 1'b1;
        end
        start = 1'b0;
        check({tag, " finished"}, 32'(seen), 32'd1);
        check({tag, " cycles"}, n, ecyc);
        for (int i = 0; i < NI; i++) begin
            check_idle_regs(tag, i, !efail, efail, e[i]);
            prior[i] = e[i];
        end
    endtask

    typedef struct {
        int         t;
        bit         ne;
        int         ncode;
        int         nk;
        bit         efail;
        int         ecyc;
        logic [5:0] e0, e1, e2;
    } vec_t;

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{64, 1'b0, 0, 0, 1'b1, 832, 6'd0,  6'd0,  6'd0};
        vecs[1]  = '{23, 1'b0, 0, 0, 1'b0, 312, 6'd23, 6'd25, 6'd28};
        vecs[2]  = '{64, 1'b0, 0, 0, 1'b1, 832, 6'd23, 6'd25, 6'd28};
        vecs[3]  = '{62, 1'b0, 0, 0, 1'b0, 819, 6'd62, 6'd63, 6'd63};
        vecs[4]  = '{62, 1'b0, 0, 0, 1'b0, 819, 6'd62, 6'd63, 6'd63};
        vecs[5]  = '{10, 1'b0, 0, 0, 1'b0, 143, 6'd10, 6'd12, 6'd15};
        vecs[6]  = '{40, 1'b1, 5, 4, 1'b0, 533, 6'd40, 6'd42, 6'd45};
        vecs[7]  = '{40, 1'b1, 5, 5, 1'b0, 78,  6'd5,  6'd7,  6'd10};
        vecs[8]  = '{1,  1'b0, 0, 0, 1'b0, 26,  6'd1,  6'd3,  6'd6};
        vecs[9]  = '{63, 1'b0, 0, 0, 1'b0, 832, 6'd63, 6'd63, 6'd63};
        vecs[10] = '{0,  1'b0, 0, 0, 1'b1, 832, 6'd63, 6'd63, 6'd63};

        areset = 1'b1; start = 1'b0; abort = 1'b0;
        thr = 64; noise_en = 1'b0; noise_code = 0; noise_k = 0;
        for (int i = 0; i < NI; i++) prior[i] = 6'd0;
        repeat (2) @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) check_idle_regs("reset", i, 1'b0, 1'b0, 6'd0);

        for (int k = 0; k < 11; k++)
            run_cal($sformatf("vec%0d", k), vecs[k].t, vecs[k].ne, vecs[k].ncode, vecs[k].nk,
                    -1, vecs[k].efail, vecs[k].ecyc, vecs[k].e0, vecs[k].e1, vecs[k].e2);

        // A start pulse mid-sweep must not restart it: done still lands at 312.
        run_cal("restart_ignored", 23, 1'b0, 0, 0, 100, 1'b0, 312, 6'd23, 6'd25, 6'd28);

        // abort while idle in DONE has no effect.
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) check_idle_regs("abort_in_done", i, 1'b1, 1'b0, prior[i]);

        // abort at code 17 falls back to the previous result.
        begin
            int n;
            thr = 40; noise_en = 1'b0;
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            n = 0;
            while (dco[0] != 6'd17 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check("abort reached_code17", 32'(dco[0]), 32'd17);
            abort = 1'b1;
            @(negedge clk); abort = 1'b0;
            for (int i = 0; i < NI; i++) check_idle_regs("abort", i, 1'b0, 1'b0, prior[i]);
            repeat (30) @(negedge clk);
            check("abort stays_idle busy", 32'(bsy[0]), 32'd0);
            check("abort stays_idle dco", 32'(dco[0]), 32'(prior[0]));
            start = 1'b1; abort = 1'b1;
            @(negedge clk); start = 1'b0; abort = 1'b0;
            repeat (20) @(negedge clk);
            for (int i = 0; i < NI; i++) check_idle_regs("abort_start", i, 1'b0, 1'b0, prior[i]);
        end

        // areset in the SAMPLE phase of code 3 clears everything before the next edge.
        begin
            int n;
            thr = 23;
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            n = 0;
            while (n < 3 * PER + 7) begin
                @(negedge clk);
                n++;
            end
            check("pre_reset busy", 32'(bsy[0]), 32'd1);
            check("pre_reset dco", 32'(dco[0]), 32'd3);
            #1 areset = 1'b1;
            #1;
            for (int i = 0; i < NI; i++) begin
                check_idle_regs("async_reset", i, 1'b0, 1'b0, 6'd0);
                prior[i] = 6'd0;
            end
            @(negedge clk); areset = 1'b0;
            repeat (20) @(negedge clk);
            check("post_reset idle busy", 32'(bsy[0]), 32'd0);
        end
        run_cal("fail_after_reset", 64, 1'b0, 0, 0, -1, 1'b1, 832, 6'd0, 6'd0, 6'd0);

        for (int r = 0; r < 8; r++) begin
            int t, ncode, nk, mcyc;
            bit ne, mfail;
            logic [5:0] m [NI];
            t     = int'($urandom_range(0, 64));
            ne    = 1'($urandom_range(0, 1));
            ncode = int'($urandom_range(1, 12));
            nk    = int'($urandom_range(0, 6));
            for (int i = 0; i < NI; i++) model(t, ne, ncode, nk, prior[i], offset_of(i), mfail, mcyc, m[i]);
            run_cal($sformatf("rand%0d", r), t, ne, ncode, nk, -1, mfail, mcyc, m[0], m[1], m[2]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
